// File: rtl/fma16_issue_seq_pkg.sv
// rtl/fma16_issue_seq_pkg.sv - shared state encoding and request/response types for the fma16 issue sequencer
package fma16_issue_seq_pkg;

  localparam int TAG_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_WAIT = WAIT;
  localparam logic [1:0] ST_RESP = RESP;

  typedef struct packed {
    logic [15:0]          x;
    logic [15:0]          y;
    logic [15:0]          z;
    logic                 mul;
    logic                 add;
    logic                 negp;
    logic                 negz;
    logic [1:0]           roundmode;
    logic [TAG_W_DEF-1:0] tag;
  } req_t;

  typedef struct packed {
    logic [15:0]          result;
    logic [3:0]           flags;
    logic [TAG_W_DEF-1:0] tag;
  } rsp_t;

endpackage

// File: rtl/fma16_issue_seq_if.sv
// rtl/fma16_issue_seq_if.sv - host request/response and fma16 operand/result signals of the issue sequencer
interface fma16_issue_seq_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [15:0]      req_x;
  logic [15:0]      req_y;
  logic [15:0]      req_z;
  logic             req_mul;
  logic             req_add;
  logic             req_negp;
  logic             req_negz;
  logic [1:0]       req_roundmode;
  logic [TAG_W-1:0] req_tag;

  logic [15:0]      fma_x;
  logic [15:0]      fma_y;
  logic [15:0]      fma_z;
  logic             fma_mul;
  logic             fma_add;
  logic             fma_negp;
  logic             fma_negz;
  logic [1:0]       fma_roundmode;
  logic [15:0]      fma_result;
  logic [3:0]       fma_flags;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [15:0]      rsp_result;
  logic [3:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;

  // master: host plus the fma16 unit; slave: the sequencer itself
  modport master (
    output req_valid, req_x, req_y, req_z, req_mul, req_add, req_negp, req_negz,
           req_roundmode, req_tag, rsp_ready, fma_result, fma_flags,
    input  req_ready, fma_x, fma_y, fma_z, fma_mul, fma_add, fma_negp, fma_negz,
           fma_roundmode, rsp_valid, rsp_result, rsp_flags, rsp_tag
  );

  modport slave (
    input  req_valid, req_x, req_y, req_z, req_mul, req_add, req_negp, req_negz,
           req_roundmode, req_tag, rsp_ready, fma_result, fma_flags,
    output req_ready, fma_x, fma_y, fma_z, fma_mul, fma_add, fma_negp, fma_negz,
           fma_roundmode, rsp_valid, rsp_result, rsp_flags, rsp_tag
  );

endinterface

// File: rtl/fma16_issue_fifo.sv
// rtl/fma16_issue_fifo.sv - request FIFO with wrap-bit pointers and first-word-fall-through head
module fma16_issue_fifo
  import fma16_issue_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  req_t push_data,
  input  logic pop,
  output logic full,
  output logic empty,
  output req_t head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  req_t        mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/fma16_issue_seq.sv
// rtl/fma16_issue_seq.sv - queues tagged fma16 requests, issues them one at a time and returns in-order responses
// Optional statistics ports are enabled by defining FMA16_ISSUE_SEQ_STATS_EN.
module fma16_issue_seq
  import fma16_issue_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int FMA_LAT = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  fma16_issue_seq_if.slave   bus
`ifdef FMA16_ISSUE_SEQ_STATS_EN
  ,
  input  logic               stat_clr,
  output logic [15:0]        stat_ops,
  output logic [3:0]         stat_flags
`endif
);

  localparam int CW = $clog2(FMA_LAT + 1);

  logic [1:0]    state;
  logic [CW-1:0] wait_cnt;
  req_t          op_q;
  rsp_t          rsp_q;
  logic          rsp_valid;

  req_t          push_data;
  req_t          head;
  logic          full;
  logic          empty;
  logic          pop;

  assign push_data = '{x:         bus.req_x,
                       y:         bus.req_y,
                       z:         bus.req_z,
                       mul:       bus.req_mul,
                       add:       bus.req_add,
                       negp:      bus.req_negp,
                       negz:      bus.req_negz,
                       roundmode: bus.req_roundmode,
                       tag:       TAG_W_DEF'(bus.req_tag)};

  // The head is consumed from IDLE, or from RESP on the response handshake.
  assign pop = !empty && ((state == ST_IDLE) || ((state == ST_RESP) && bus.rsp_ready));

  fma16_issue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (bus.req_valid),
    .push_data (push_data),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  assign bus.req_ready = !full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      op_q      <= '0;
      rsp_q     <= '0;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            op_q     <= head;
            wait_cnt <= CW'(FMA_LAT);
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - CW'(1);
          if (wait_cnt == CW'(1)) begin
            rsp_q     <= '{result: bus.fma_result, flags: bus.fma_flags, tag: op_q.tag};
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            if (pop) begin
              op_q     <= head;
              wait_cnt <= CW'(FMA_LAT);
              state    <= ST_WAIT;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.fma_x         = op_q.x;
  assign bus.fma_y         = op_q.y;
  assign bus.fma_z         = op_q.z;
  assign bus.fma_mul       = op_q.mul;
  assign bus.fma_add       = op_q.add;
  assign bus.fma_negp      = op_q.negp;
  assign bus.fma_negz      = op_q.negz;
  assign bus.fma_roundmode = op_q.roundmode;

  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_result = rsp_q.result;
  assign bus.rsp_flags  = rsp_q.flags;
  assign bus.rsp_tag    = TAG_W'(rsp_q.tag);

`ifdef FMA16_ISSUE_SEQ_STATS_EN
  logic rsp_hs;
  assign rsp_hs = rsp_valid && bus.rsp_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_ops   <= '0;
      stat_flags <= '0;
    end else if (stat_clr) begin
      stat_ops   <= '0;
      stat_flags <= '0;
    end else if (rsp_hs) begin
      if (stat_ops != 16'hFFFF) begin
        stat_ops <= stat_ops + 16'd1;
      end
      stat_flags <= stat_flags | rsp_q.flags;
    end
  end
`endif

endmodule

// File: tb/tb_fma16_issue_seq.sv
// tb/tb_fma16_issue_seq.sv - directed self-checking bench for fma16_issue_seq with a stub fma16 unit
module tb_fma16_issue_seq;
  import fma16_issue_seq_pkg::*;

`ifdef FMA16_ISSUE_SEQ_STATS_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  fma16_issue_seq_if #(.TAG_W(TAG_W_DEF)) bus ();

`ifdef FMA16_ISSUE_SEQ_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_ops;
  logic [3:0]  stat_flags;
`endif

  fma16_issue_seq #(
    .DEPTH   (DEPTH),
    .TAG_W   (TAG_W_DEF),
    .FMA_LAT (LAT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus)
`ifdef FMA16_ISSUE_SEQ_STATS_EN
    ,
    .stat_clr   (stat_clr),
    .stat_ops   (stat_ops),
    .stat_flags (stat_flags)
`endif
  );

  always #5 clk = ~clk;

  // Stub fma16: exact results for the directed vectors, otherwise x^y^z with flags {negp,negz,rm}.
  always_comb begin
    if (bus.fma_x == 16'h4000 && bus.fma_y == 16'h4200 && bus.fma_z == 16'h3C00 && bus.fma_mul && bus.fma_add) begin
      bus.fma_result = 16'h4700;
      bus.fma_flags  = 4'h0;
    end else if (bus.fma_x == 16'h3C00 && bus.fma_y == 16'h3C00 && bus.fma_z == 16'h0000) begin
      bus.fma_result = 16'h3C00;
      bus.fma_flags  = 4'h0;
    end else begin
      bus.fma_result = bus.fma_x ^ bus.fma_y ^ bus.fma_z;
      bus.fma_flags  = {bus.fma_negp, bus.fma_negz, bus.fma_roundmode};
    end
  end

  logic [3:0]  q_tag[$];
  logic [15:0] q_res[$];
  logic [3:0]  q_flg[$];
  longint      q_t[$];

  always @(posedge clk) begin
    if (bus.rsp_valid && bus.rsp_ready) begin
      q_tag.push_back(bus.rsp_tag);
      q_res.push_back(bus.rsp_result);
      q_flg.push_back(bus.rsp_flags);
      q_t.push_back(longint'($time));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                      input logic mul, input logic add, input logic negp, input logic negz,
                      input logic [1:0] rm, input logic [3:0] tag);
    int n = 0;
    bus.req_x = x; bus.req_y = y; bus.req_z = z;
    bus.req_mul = mul; bus.req_add = add; bus.req_negp = negp; bus.req_negz = negz;
    bus.req_roundmode = rm; bus.req_tag = tag;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && n < 50) begin
      tick(1);
      n++;
    end
    tick(1);
    bus.req_valid = 1'b0;
  endtask

  task automatic single(input string nm, input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                        input logic mul, input logic add, input logic negp, input logic negz,
                        input logic [1:0] rm, input logic [3:0] tag,
                        input logic [15:0] exp_res, input logic [3:0] exp_flg);
    int cyc = 0;
    bus.rsp_ready = 1'b1;
    push(x, y, z, mul, add, negp, negz, rm, tag);
    while (!bus.rsp_valid && cyc < 40) begin
      tick(1);
      cyc++;
    end
    chk({nm, "_latency"}, cyc, LAT + 1);
    chk({nm, "_result"}, bus.rsp_result, exp_res);
    chk({nm, "_flags"}, bus.rsp_flags, exp_flg);
    chk({nm, "_tag"}, bus.rsp_tag, tag);
    tick(1);
    chk({nm, "_valid_drop"}, bus.rsp_valid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    int acc;
    logic rdy;
    logic [15:0] hold_res;

    reset_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_x = '0; bus.req_y = '0; bus.req_z = '0;
    bus.req_mul = 1'b0; bus.req_add = 1'b0; bus.req_negp = 1'b0; bus.req_negz = 1'b0;
    bus.req_roundmode = '0; bus.req_tag = '0; bus.rsp_ready = 1'b0;
`ifdef FMA16_ISSUE_SEQ_STATS_EN
    stat_clr = 1'b0;
`endif

    // Reset state, with a push attempt that must be ignored
    tick(2);
    bus.req_valid = 1'b1; bus.req_tag = 4'hF; bus.req_x = 16'h7777;
    tick(1);
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_fma_x", bus.fma_x, 16'h0);
    chk("rst_fma_rm", bus.fma_roundmode, 2'b00);
    chk("rst_rsp_result", bus.rsp_result, 16'h0);
    chk("rst_rsp_tag", bus.rsp_tag, 4'h0);
    bus.req_valid = 1'b0;
    reset_n = 1'b1;
    tick(4);
    chk("rst_no_push_valid", bus.rsp_valid, 1'b0);
    chk("rst_no_push_fma_x", bus.fma_x, 16'h0);

    // Single request: 2*3+1 = 7
    single("t1", 16'h4000, 16'h4200, 16'h3C00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 4'd3, 16'h4700, 4'h0);
    chk("t1_fma_x", bus.fma_x, 16'h4000);
    chk("t1_fma_y", bus.fma_y, 16'h4200);
    chk("t1_fma_z", bus.fma_z, 16'h3C00);
    chk("t1_fma_rm", bus.fma_roundmode, 2'b01);
    chk("t1_fma_mul_add", {bus.fma_mul, bus.fma_add}, 2'b11);

    // Four back-to-back requests, rsp_ready high
    base = q_tag.size();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(16'h3C00, 16'h3C00, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, i[3:0]);
    end
    n = 0;
    while (q_tag.size() < base + 4 && n < 100) begin
      tick(1);
      n++;
    end
    chk("t2_count", q_tag.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < q_tag.size()) begin
        chk($sformatf("t2_tag%0d", i), q_tag[base+i], i);
        chk($sformatf("t2_res%0d", i), q_res[base+i], 16'h3C00);
        if (i > 0) chk($sformatf("t2_gap%0d", i), 32'(q_t[base+i] - q_t[base+i-1]), (LAT + 1) * 10);
      end
    end

    // Capacity with rsp_ready low: DEPTH+1 accepted
    bus.rsp_ready = 1'b0;
    acc = 0;
    bus.req_x = 16'h1000; bus.req_y = 16'h0000; bus.req_z = 16'h0000;
    bus.req_mul = 1'b1; bus.req_add = 1'b1; bus.req_negp = 1'b0; bus.req_negz = 1'b0;
    bus.req_roundmode = 2'b10; bus.req_tag = 4'd0;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rdy = bus.req_ready;
      tick(1);
      if (rdy) begin
        acc++;
        bus.req_tag = acc[3:0];
        bus.req_x   = 16'h1000 + 16'(acc);
      end
    end
    bus.req_valid = 1'b0;
    chk("t3_accepted", acc, DEPTH + 1);
    chk("t3_req_ready_low", bus.req_ready, 1'b0);
    base = q_tag.size();
    bus.rsp_ready = 1'b1;
    tick(1);
    chk("t3_req_ready_back", bus.req_ready, 1'b1);
    n = 0;
    while (q_tag.size() < base + 5 && n < 100) begin
      tick(1);
      n++;
    end
    chk("t3_count", q_tag.size() - base, 5);
    for (int i = 0; i < 5; i++) begin
      if (base + i < q_tag.size()) begin
        chk($sformatf("t3_tag%0d", i), q_tag[base+i], i);
        chk($sformatf("t3_res%0d", i), q_res[base+i], 16'h1000 + i);
        chk($sformatf("t3_flg%0d", i), q_flg[base+i], 4'h2);
      end
    end

    // Response backpressure: 1234^00F0 = 12C4, flags {1,0,11}
    bus.rsp_ready = 1'b0;
    push(16'h1234, 16'h00F0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 4'hA);
    n = 0;
    while (!bus.rsp_valid && n < 40) begin
      tick(1);
      n++;
    end
    chk("t4_result", bus.rsp_result, 16'h12C4);
    chk("t4_flags", bus.rsp_flags, 4'hB);
    chk("t4_tag", bus.rsp_tag, 4'hA);
    hold_res = bus.rsp_result;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      chk($sformatf("t4_hold_valid%0d", i), bus.rsp_valid, 1'b1);
      chk($sformatf("t4_hold_res%0d", i), bus.rsp_result, hold_res);
      chk($sformatf("t4_hold_meta%0d", i), {bus.rsp_flags, bus.rsp_tag}, {4'hB, 4'hA});
    end
    bus.rsp_ready = 1'b1;
    tick(1);
    chk("t4_valid_drop", bus.rsp_valid, 1'b0);

    // Reset while WAIT with two requests queued
    bus.rsp_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      push(16'h3C00, 16'h3C00, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, i[3:0]);
    end
    n = 0;
    while (!bus.rsp_valid && n < 40) begin
      tick(1);
      n++;
    end
    bus.rsp_ready = 1'b1;
    tick(1);
    bus.rsp_ready = 1'b0;
    reset_n = 1'b0;
    #2;
    chk("t5_rsp_valid", bus.rsp_valid, 1'b0);
    chk("t5_fma_x", bus.fma_x, 16'h0);
    chk("t5_fma_mul", bus.fma_mul, 1'b0);
    chk("t5_rsp_result", bus.rsp_result, 16'h0);
    chk("t5_rsp_tag", bus.rsp_tag, 4'h0);
    chk("t5_req_ready", bus.req_ready, 1'b1);
    base = q_tag.size();
    tick(1);
    reset_n = 1'b1;
    bus.rsp_ready = 1'b1;
    tick(10);
    chk("t5_no_responses", q_tag.size() - base, 0);
    chk("t5_valid_after", bus.rsp_valid, 1'b0);
    chk("t5_ready_after", bus.req_ready, 1'b1);

`ifdef FMA16_ISSUE_SEQ_STATS_EN
    chk("s_reset_ops", stat_ops, 16'd0);
    chk("s_reset_flags", stat_flags, 4'h0);
    single("s1", 16'h3C00, 16'h3C00, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'd5, 16'h3C00, 4'h0);
    single("s2", 16'h3C00, 16'h3C00, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'd6, 16'h3C00, 4'h0);
    single("s3", 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 4'd7, 16'h0001, 4'h5);
    chk("s_ops", stat_ops, 16'd3);
    chk("s_flags", stat_flags, 4'h5);
    stat_clr = 1'b1;
    tick(1);
    stat_clr = 1'b0;
    chk("s_clr_ops", stat_ops, 16'd0);
    chk("s_clr_flags", stat_flags, 4'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
